// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states
// and the byte-strobe generator used for both beats of an access.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int MAX_B = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ1  = 3'd1,
        RESP1 = 3'd2,
        REQ2  = 3'd3,
        RESP2 = 3'd4,
        DONE  = 3'd5
    } state_e;

    // Byte i of a beat is enabled when its position in the 2B-byte window
    // falls inside [off, off+n); beat 2 covers window positions nb..2nb-1.
    function automatic logic [MAX_B-1:0] strb_gen(
        input logic [3:0] off,
        input logic [3:0] n,
        input logic       beat,
        input logic [3:0] nb
    );
        logic [MAX_B-1:0] m;
        int               pos;
        m = 8'h00;
        for (int i = 0; i < MAX_B; i++) begin
            pos  = beat ? (i + int'(nb)) : i;
            m[i] = (i < int'(nb)) && (pos >= int'(off)) && (pos < (int'(off) + int'(n)));
        end
        return m;
    endfunction

endpackage

// File: rtl/mem_align_merge.sv
// Combinational data path: shifts store data into the two-beat window and
// merges/extends the two read beats into a right-justified load result.
module mem_align_merge
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [$clog2(XLEN/8)-1:0] off,
    input  logic [1:0]                size,
    input  logic                      uns,
    input  logic [XLEN-1:0]           wdata,
    output logic [XLEN-1:0]           wbeat_lo,
    output logic [XLEN-1:0]           wbeat_hi,
    input  logic [XLEN-1:0]           rbeat_lo,
    input  logic [XLEN-1:0]           rbeat_hi,
    output logic [XLEN-1:0]           rdata
);

    logic [2*XLEN-1:0] w_wide_s;
    logic [XLEN-1:0]   r_sh_s;
    int                nbits_s;
    logic              sgn_s;

    // Shift both directions by the byte offset, then extend above 8n bits.
    always_comb begin
        w_wide_s = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
        wbeat_lo = w_wide_s[XLEN-1:0];
        wbeat_hi = w_wide_s[2*XLEN-1:XLEN];
        r_sh_s   = XLEN'({rbeat_hi, rbeat_lo} >> {off, 3'b000});
        nbits_s  = XLEN;
        sgn_s    = 1'b0;
        rdata    = {XLEN{1'b0}};
        case (size)
            SZ_B:    begin nbits_s = 8;    sgn_s = r_sh_s[7];      end
            SZ_H:    begin nbits_s = 16;   sgn_s = r_sh_s[15];     end
            SZ_W:    begin nbits_s = 32;   sgn_s = r_sh_s[31];     end
            default: begin nbits_s = XLEN; sgn_s = r_sh_s[XLEN-1]; end
        endcase
        for (int i = 0; i < XLEN; i++) begin
            if (i < nbits_s) begin
                rdata[i] = r_sh_s[i];
            end else begin
                rdata[i] = sgn_s & ~uns;
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one access at a time, split into one or two aligned
// memory beats, with merged/extended read data and a stall-cycle counter.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [XLEN-1:0]     req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic                resp_err,
    output logic [XLEN-1:0]     mem_addr,
    output logic                mem_read,
    output logic                mem_write,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_req_ack,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_rdata_valid,
    output logic                mem_rdata_ack,
    output logic [31:0]         stall_cnt
);

    localparam int B  = XLEN / 8;
    localparam int OW = $clog2(B);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [XLEN-1:0]   beat1_q, beat1_d;
    logic [31:0]       stall_q, stall_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [B-1:0]      mem_wstrb_q, mem_wstrb_d;
    logic              mem_rdata_ack_q, mem_rdata_ack_d;

    logic [OW-1:0]     off_s;
    logic [3:0]        n_s;
    logic              cross_s;
    logic              illegal_s;
    logic [XLEN-1:0]   base_s;
    logic              in_req_s;
    logic              is_req2_s;
    logic [MAX_B-1:0]  strb8_s;
    logic [XLEN-1:0]   wbeat_lo_s, wbeat_hi_s;
    logic [XLEN-1:0]   rbeat_lo_s;
    logic [XLEN-1:0]   merged_s;

    // Latch the request in IDLE; the captured copy drives the rest of the access.
    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if ((state_q == IDLE) && req_valid) begin
            we_d    = req_we;
            size_d  = req_size;
            uns_d   = req_unsigned;
            addr_d  = req_addr;
            wdata_d = req_wdata;
        end else begin
            we_d    = we_q;
        end
    end

    assign off_s     = addr_d[OW-1:0];
    assign n_s       = 4'd1 << size_d;
    assign cross_s   = (5'(off_s) + 5'(n_s)) > 5'(B);
    assign illegal_s = ((size_d == SZ_D) && (XLEN == 32)) || (cross_s && (ALLOW_MISALIGN == 1'b0));
    assign base_s    = {addr_d[XLEN-1:OW], {OW{1'b0}}};
    // Beat 1 is taken live from the bus when the access completes straight out of RESP1.
    assign rbeat_lo_s = (state_q == RESP1) ? mem_rdata : beat1_q;

    mem_align_merge #(.XLEN(XLEN)) u_align (
        .off      (off_s),
        .size     (size_d),
        .uns      (uns_d),
        .wdata    (wdata_d),
        .wbeat_lo (wbeat_lo_s),
        .wbeat_hi (wbeat_hi_s),
        .rbeat_lo (rbeat_lo_s),
        .rbeat_hi (mem_rdata),
        .rdata    (merged_s)
    );

    // Next state, beat capture and stall counting.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        beat1_d = beat1_q;
        stall_d = stall_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    err_d   = illegal_s;
                    state_d = illegal_s ? DONE : REQ1;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ1: begin
                if (mem_req_ack) begin
                    state_d = !we_d ? RESP1 : (cross_s ? REQ2 : DONE);
                end else begin
                    stall_d = stall_q + 32'd1;
                end
            end
            RESP1: begin
                if (mem_rdata_valid) begin
                    beat1_d = mem_rdata;
                    state_d = cross_s ? REQ2 : DONE;
                end else begin
                    stall_d = stall_q + 32'd1;
                end
            end
            REQ2: begin
                if (mem_req_ack) begin
                    state_d = we_d ? DONE : RESP2;
                end else begin
                    stall_d = stall_q + 32'd1;
                end
            end
            RESP2: begin
                if (mem_rdata_valid) begin
                    state_d = DONE;
                end else begin
                    stall_d = stall_q + 32'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        in_req_s        = (state_d == REQ1) || (state_d == REQ2);
        is_req2_s       = (state_d == REQ2);
        strb8_s         = strb_gen(4'(off_s), n_s, is_req2_s, 4'(B));
        mem_read_d      = in_req_s && !we_d;
        mem_write_d     = in_req_s && we_d;
        mem_addr_d      = in_req_s ? (is_req2_s ? (base_s + XLEN'(B)) : base_s) : {XLEN{1'b0}};
        mem_wstrb_d     = mem_write_d ? B'(strb8_s) : {B{1'b0}};
        mem_wdata_d     = mem_write_d ? (is_req2_s ? wbeat_hi_s : wbeat_lo_s) : {XLEN{1'b0}};
        mem_rdata_ack_d = (state_d == RESP1) || (state_d == RESP2);
        req_ready_d     = (state_d == IDLE);
        resp_valid_d    = (state_d == DONE);
        resp_err_d      = (state_d == DONE) && err_d;
        resp_rdata_d    = ((state_d == DONE) && !err_d && !we_d) ? merged_s : {XLEN{1'b0}};
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            we_q            <= 1'b0;
            size_q          <= 2'd0;
            uns_q           <= 1'b0;
            addr_q          <= {XLEN{1'b0}};
            wdata_q         <= {XLEN{1'b0}};
            err_q           <= 1'b0;
            beat1_q         <= {XLEN{1'b0}};
            stall_q         <= 32'd0;
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= {XLEN{1'b0}};
            resp_err_q      <= 1'b0;
            mem_addr_q      <= {XLEN{1'b0}};
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_wdata_q     <= {XLEN{1'b0}};
            mem_wstrb_q     <= {B{1'b0}};
            mem_rdata_ack_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            we_q            <= we_d;
            size_q          <= size_d;
            uns_q           <= uns_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            err_q           <= err_d;
            beat1_q         <= beat1_d;
            stall_q         <= stall_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_err_q      <= resp_err_d;
            mem_addr_q      <= mem_addr_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_wstrb_q     <= mem_wstrb_d;
            mem_rdata_ack_q <= mem_rdata_ack_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign mem_addr      = mem_addr_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign mem_rdata_ack = mem_rdata_ack_q;
    assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a small memory model with per-beat ack
// waits, plus a second instance with misaligned accesses disallowed.
module tb_mem_access_unit;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid_nm;
    logic        req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, stall_cnt;
    logic        mem_read, mem_write, mem_rdata_ack;
    logic [3:0]  mem_wstrb;
    logic        mem_req_ack, mem_rdata_valid;
    logic [31:0] mem_rdata;

    logic        nm_req_ready, nm_resp_valid, nm_resp_err;
    logic [31:0] nm_resp_rdata, nm_mem_addr, nm_mem_wdata, nm_stall_cnt;
    logic        nm_mem_read, nm_mem_write, nm_mem_rdata_ack;
    logic [3:0]  nm_mem_wstrb;

    always #5 clk = ~clk;

    mem_access_unit #(.XLEN(32), .ALLOW_MISALIGN(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_addr(mem_addr),
        .mem_read(mem_read), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_req_ack(mem_req_ack), .mem_rdata(mem_rdata),
        .mem_rdata_valid(mem_rdata_valid), .mem_rdata_ack(mem_rdata_ack),
        .stall_cnt(stall_cnt)
    );

    mem_access_unit #(.XLEN(32), .ALLOW_MISALIGN(1'b0)) dut_nm (
        .clk(clk), .rst(rst), .req_valid(req_valid_nm), .req_ready(nm_req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(nm_resp_valid),
        .resp_rdata(nm_resp_rdata), .resp_err(nm_resp_err), .mem_addr(nm_mem_addr),
        .mem_read(nm_mem_read), .mem_write(nm_mem_write), .mem_wdata(nm_mem_wdata),
        .mem_wstrb(nm_mem_wstrb), .mem_req_ack(1'b0), .mem_rdata(32'h0000_0000),
        .mem_rdata_valid(1'b0), .mem_rdata_ack(nm_mem_rdata_ack),
        .stall_cnt(nm_stall_cnt)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          start;
    } resp_t;

    logic [31:0] mem [0:255];
    beat_t       exp_beats[$];
    resp_t       sb[$];
    resp_t       sb_nm[$];
    int          waits[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          exp_stall = 0;
    int          pend = -1;
    logic        rd_pending = 1'b0;
    logic [31:0] rd_data = 32'h0000_0000;
    logic        hold_rdata = 1'b0;
    logic        stray = 1'b0;
    logic        nm_traffic = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] smask(input logic [3:0] s);
        logic [31:0] m;
        for (int k = 0; k < 4; k++) m[8*k +: 8] = {8{s[k]}};
        return m;
    endfunction

    task automatic add_beat(input logic we, input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wdata);
        beat_t b;
        b.we = we; b.addr = addr; b.strb = strb; b.wdata = wdata;
        exp_beats.push_back(b);
    endtask

    // Memory model: acks after the queued wait count, returns read data one cycle later.
    initial begin
        mem_req_ack = 1'b0;
        mem_rdata_valid = 1'b0;
        mem_rdata = 32'h0000_0000;
        forever begin
            beat_t b;
            @(posedge clk);
            #1;
            if ((rd_pending && mem_rdata_ack && !hold_rdata) || stray) begin
                mem_rdata_valid = 1'b1;
                mem_rdata = rd_data;
                rd_pending = 1'b0;
                stray = 1'b0;
            end else begin
                mem_rdata_valid = 1'b0;
            end
            if (mem_read || mem_write) begin
                if (pend < 0) pend = (waits.size() > 0) ? waits.pop_front() : 0;
                if (pend == 0) begin
                    mem_req_ack = 1'b1;
                    pend = -1;
                    if (exp_beats.size() == 0) begin
                        check("unexpected_beat", {31'd0, mem_read | mem_write}, 32'd0);
                    end else begin
                        b = exp_beats.pop_front();
                        check("beat_we", {31'd0, mem_write}, {31'd0, b.we});
                        check("beat_addr", mem_addr, b.addr);
                        if (b.we) begin
                            check("beat_strb", {28'd0, mem_wstrb}, {28'd0, b.strb});
                            check("beat_wdata", mem_wdata & smask(mem_wstrb), b.wdata);
                        end
                    end
                    if (mem_write) begin
                        for (int k = 0; k < 4; k++)
                            if (mem_wstrb[k]) mem[mem_addr[9:2]][8*k +: 8] = mem_wdata[8*k +: 8];
                    end else begin
                        rd_data = mem[mem_addr[9:2]];
                        rd_pending = 1'b1;
                    end
                end else begin
                    mem_req_ack = 1'b0;
                    pend--;
                end
            end else begin
                mem_req_ack = 1'b0;
                pend = -1;
            end
        end
    end

    // Response monitor for both instances.
    initial begin
        forever begin
            resp_t r;
            @(negedge clk);
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    r = sb.pop_front();
                    check("resp_rdata", resp_rdata, r.rdata);
                    check("resp_err", {31'd0, resp_err}, {31'd0, r.err});
                    check("resp_latency", cyc - r.start, r.lat);
                end
            end
            if (nm_resp_valid) begin
                if (sb_nm.size() == 0) begin
                    check("nm_unexpected_resp", 32'd1, 32'd0);
                end else begin
                    r = sb_nm.pop_front();
                    check("nm_resp_rdata", nm_resp_rdata, r.rdata);
                    check("nm_resp_err", {31'd0, nm_resp_err}, {31'd0, r.err});
                    check("nm_resp_latency", cyc - r.start, r.lat);
                end
            end
            if (nm_mem_read || nm_mem_write) nm_traffic = 1'b1;
        end
    end

    task automatic issue(input logic nm, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                         input logic expect_resp);
        resp_t r;
        @(posedge clk);
        #1;
        req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
        if (nm) req_valid_nm = 1'b1; else req_valid = 1'b1;
        r.rdata = exp_rdata; r.err = exp_err; r.lat = exp_lat; r.start = cyc;
        if (expect_resp) begin
            if (nm) sb_nm.push_back(r); else sb.push_back(r);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_valid_nm = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && (sb.size() != 0 || sb_nm.size() != 0); i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("done_timeout", sb.size() + sb_nm.size(), 32'd0);
        check("beats_left", exp_beats.size(), 32'd0);
        check("stall_cnt", stall_cnt, exp_stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_valid_nm = 1'b0; req_we = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0000;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_mem_write", {31'd0, mem_write}, 32'd0);
        check("rst_rdata_ack", {31'd0, mem_rdata_ack}, 32'd0);
        check("rst_stall", stall_cnt, 32'd0);
        check("rst_nm_req_ready", {31'd0, nm_req_ready}, 32'd1);
        rst = 1'b0;

        // aligned store / load back
        add_beat(1'b1, 32'h100, 4'b1111, 32'hDEADBEEF);
        issue(1'b0, 1'b1, SZ_W, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1);
        wait_done();
        add_beat(1'b0, 32'h100, 4'b0000, 32'h0);
        issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1);
        wait_done();

        // byte loads, signed and unsigned
        mem[64] = 32'h80FF1234;
        add_beat(1'b0, 32'h100, 4'b0000, 32'h0);
        issue(1'b0, 1'b0, SZ_B, 1'b0, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b1);
        wait_done();
        add_beat(1'b0, 32'h100, 4'b0000, 32'h0);
        issue(1'b0, 1'b0, SZ_B, 1'b1, 32'h103, 32'h0, 32'h00000080, 1'b0, 3, 1'b1);
        wait_done();

        // byte store at offset 1
        add_beat(1'b1, 32'h100, 4'b0010, 32'h00005A00);
        issue(1'b0, 1'b1, SZ_B, 1'b0, 32'h101, 32'h0000005A, 32'h0, 1'b0, 2, 1'b1);
        wait_done();
        add_beat(1'b0, 32'h100, 4'b0000, 32'h0);
        issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h80FF5A34, 1'b0, 3, 1'b1);
        wait_done();

        // split half store, then split half loads back
        add_beat(1'b1, 32'h100, 4'b1000, 32'hCD000000);
        add_beat(1'b1, 32'h104, 4'b0001, 32'h000000AB);
        issue(1'b0, 1'b1, SZ_H, 1'b0, 32'h103, 32'h0000ABCD, 32'h0, 1'b0, 3, 1'b1);
        wait_done();
        add_beat(1'b0, 32'h100, 4'b0000, 32'h0);
        add_beat(1'b0, 32'h104, 4'b0000, 32'h0);
        issue(1'b0, 1'b0, SZ_H, 1'b0, 32'h103, 32'h0, 32'hFFFFABCD, 1'b0, 5, 1'b1);
        wait_done();
        add_beat(1'b0, 32'h100, 4'b0000, 32'h0);
        add_beat(1'b0, 32'h104, 4'b0000, 32'h0);
        issue(1'b0, 1'b0, SZ_H, 1'b1, 32'h103, 32'h0, 32'h0000ABCD, 1'b0, 5, 1'b1);
        wait_done();

        // split word load with 3 ack waits on beat 2
        mem[64] = 32'h11223344;
        mem[65] = 32'h55667788;
        waits.push_back(0);
        waits.push_back(3);
        add_beat(1'b0, 32'h100, 4'b0000, 32'h0);
        add_beat(1'b0, 32'h104, 4'b0000, 32'h0);
        issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h102, 32'h0, 32'h77881122, 1'b0, 8, 1'b1);
        exp_stall = 3;
        wait_done();

        // aligned sub-word at offset 2 is a single beat
        mem[64] = 32'h80013344;
        add_beat(1'b0, 32'h100, 4'b0000, 32'h0);
        issue(1'b0, 1'b0, SZ_H, 1'b0, 32'h102, 32'h0, 32'hFFFF8001, 1'b0, 3, 1'b1);
        wait_done();
        add_beat(1'b0, 32'h100, 4'b0000, 32'h0);
        issue(1'b0, 1'b0, SZ_H, 1'b1, 32'h102, 32'h0, 32'h00008001, 1'b0, 3, 1'b1);
        wait_done();

        // illegal size on the misalign-capable instance
        issue(1'b0, 1'b0, SZ_D, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        wait_done();

        // misalign-disallowed instance
        issue(1'b1, 1'b0, SZ_W, 1'b0, 32'h101, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        wait_done();
        issue(1'b1, 1'b0, SZ_D, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b1);
        wait_done();

        // reset while waiting in RESP1
        hold_rdata = 1'b1;
        add_beat(1'b0, 32'h100, 4'b0000, 32'h0);
        issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h0, 1'b0, 0, 1'b0);
        for (int i = 0; i < 20 && !mem_rdata_ack; i++) begin
            @(posedge clk);
            #1;
        end
        check("reached_resp1", {31'd0, mem_rdata_ack}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rdata_ack", {31'd0, mem_rdata_ack}, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        check("abort_mem_read", {31'd0, mem_read}, 32'd0);
        check("abort_stall", stall_cnt, 32'd0);
        rst = 1'b0;
        rd_pending = 1'b0;
        hold_rdata = 1'b0;
        stray = 1'b1;
        exp_stall = 0;
        repeat (6) @(posedge clk);

        // recovery access after the abort
        add_beat(1'b0, 32'h100, 4'b0000, 32'h0);
        issue(1'b0, 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h80013344, 1'b0, 3, 1'b1);
        wait_done();

        check("nm_no_traffic", {31'd0, nm_traffic}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
